// File: rtl/addr_gen_hc_wr_if.sv
`default_nettype none
// ============================================================================
// Module      : addr_gen_hc_wr_if
// Description : Bundle of the producer-side handshake and the H/C memory
//               write port served by addr_gen_hc_wr.
//               slave  : seen by addr_gen_hc_wr (consumes start/i_*, drives o_*)
//               master : seen by the environment (drives start/i_*, reads o_*)
// Signals     : start, i_valid, i_h, i_c            -> generator
//               o_wr_en, o_addr_h, o_addr_c,
//               o_data_h, o_data_c, o_ts_done,
//               o_busy, o_done                      <- generator
// Revision    : 1.0  initial release
// ============================================================================
interface addr_gen_hc_wr_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_h;
    logic [DATA_WIDTH-1:0] i_c;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_addr_h;
    logic [ADDR_WIDTH-1:0] o_addr_c;
    logic [DATA_WIDTH-1:0] o_data_h;
    logic [DATA_WIDTH-1:0] o_data_c;
    logic                  o_ts_done;
    logic                  o_busy;
    logic                  o_done;

    modport slave (
        input  start, i_valid, i_h, i_c,
        output o_wr_en, o_addr_h, o_addr_c, o_data_h, o_data_c,
               o_ts_done, o_busy, o_done
    );

    modport master (
        output start, i_valid, i_h, i_c,
        input  o_wr_en, o_addr_h, o_addr_c, o_data_h, o_data_c,
               o_ts_done, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/addr_gen_hc_wr.sv
`default_nettype none
// ============================================================================
// Module      : addr_gen_hc_wr
// Description : Write-side address generator for the H/C state memories.
//               A pass first zeroes the t=-1 region (0..NUM_CELL-1), then
//               writes each incoming h/c pair at NUM_CELL*(t+1)+cell, pulsing
//               o_ts_done on the last cell of every timestep and finishing in
//               DONE after address NUM_CELL*(TIMESTEP+1)-1.
// Ports       : clk       rising-edge clock
//               rst_n     asynchronous active-low reset
//               bus       addr_gen_hc_wr_if.slave
//                         start/i_valid/i_h/i_c in; write port, o_ts_done,
//                         o_busy (decoded from state), o_done out
// Revision    : 1.0  initial release
// ============================================================================
module addr_gen_hc_wr #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int TIMESTEP   = 7,
    parameter int NUM_CELL   = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    addr_gen_hc_wr_if.slave  bus
);

    localparam int c_CELL_W = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1;

    localparam logic [ADDR_WIDTH-1:0] c_CLR_LAST  = ADDR_WIDTH'(NUM_CELL - 1);
    localparam logic [ADDR_WIDTH-1:0] c_RUN_BASE  = ADDR_WIDTH'(NUM_CELL);
    localparam logic [ADDR_WIDTH-1:0] c_PASS_LAST = ADDR_WIDTH'(NUM_CELL * (TIMESTEP + 1) - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE       = ADDR_WIDTH'(1);
    localparam logic [c_CELL_W-1:0]   c_CELL_LAST = c_CELL_W'(NUM_CELL - 1);
    localparam logic [c_CELL_W-1:0]   c_CELL_ONE  = c_CELL_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CLEAR = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]            state_q,   state_d;
    logic [ADDR_WIDTH-1:0] ptr_q,     ptr_d;
    logic [c_CELL_W-1:0]   cell_q,    cell_d;
    logic                  wr_en_q,   wr_en_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] data_h_q,  data_h_d;
    logic [DATA_WIDTH-1:0] data_c_q,  data_c_d;
    logic                  ts_done_q, ts_done_d;
    logic                  done_q,    done_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE, c_ST_DONE: begin
                if (bus.start) begin
                    // A single-cell layout is fully cleared by the start write.
                    state_d = (NUM_CELL == 1) ? c_ST_RUN : c_ST_CLEAR;
                end
            end
            c_ST_CLEAR: begin
                // Leave on the edge that issues the last zero write.
                if ((addr_q + c_ONE) == c_CLR_LAST) begin
                    state_d = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (bus.i_valid && (ptr_q == c_PASS_LAST)) begin
                    state_d = c_ST_DONE;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        wr_en_d   = 1'b0;
        ts_done_d = 1'b0;
        addr_d    = addr_q;
        data_h_d  = data_h_q;
        data_c_d  = data_c_q;
        ptr_d     = ptr_q;
        cell_d    = cell_q;
        done_d    = done_q;

        case (state_q)
            c_ST_IDLE, c_ST_DONE: begin
                if (bus.start) begin
                    wr_en_d  = 1'b1;
                    addr_d   = '0;
                    data_h_d = '0;
                    data_c_d = '0;
                    done_d   = 1'b0;
                end
            end
            c_ST_CLEAR: begin
                wr_en_d  = 1'b1;
                addr_d   = addr_q + c_ONE;
                data_h_d = '0;
                data_c_d = '0;
            end
            c_ST_RUN: begin
                if (bus.i_valid) begin
                    wr_en_d   = 1'b1;
                    addr_d    = ptr_q;
                    data_h_d  = bus.i_h;
                    data_c_d  = bus.i_c;
                    ptr_d     = ptr_q + c_ONE;
                    ts_done_d = (cell_q == c_CELL_LAST);
                    cell_d    = (cell_q == c_CELL_LAST) ? '0 : (cell_q + c_CELL_ONE);
                    if (ptr_q == c_PASS_LAST) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                wr_en_d = 1'b0;
            end
        endcase

        // The write pointer starts at the first t=0 slot whenever RUN is entered.
        if ((state_q != c_ST_RUN) && (state_d == c_ST_RUN)) begin
            ptr_d  = c_RUN_BASE;
            cell_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath / registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            cell_q    <= '0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_h_q  <= '0;
            data_c_q  <= '0;
            ts_done_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            cell_q    <= cell_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_h_q  <= data_h_d;
            data_c_q  <= data_c_d;
            ts_done_q <= ts_done_d;
            done_q    <= done_d;
        end
    end

    // H and C memories share one address register.
    assign bus.o_wr_en   = wr_en_q;
    assign bus.o_addr_h  = addr_q;
    assign bus.o_addr_c  = addr_q;
    assign bus.o_data_h  = data_h_q;
    assign bus.o_data_c  = data_c_q;
    assign bus.o_ts_done = ts_done_q;
    assign bus.o_done    = done_q;
    assign bus.o_busy    = (state_q == c_ST_CLEAR) || (state_q == c_ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_addr_gen_hc_wr.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_gen_hc_wr
// Description : Self-checking bench for addr_gen_hc_wr. A pass-level model
//               (clear count / run write count) predicts every output each
//               cycle; literal checks pin key points of the model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_addr_gen_hc_wr;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int TS = 7;
    localparam int NC = 8;
    localparam int LAST = NC * (TS + 1) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    addr_gen_hc_wr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    addr_gen_hc_wr #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMESTEP(TS), .NUM_CELL(NC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- pass-level model ----------------
    // phase: 0 idle, 1 clearing, 2 running, 3 finished
    int          m_phase = 0;
    int          m_clr   = 0;   // zero writes issued so far
    int          m_nwr   = 0;   // data writes issued so far in this pass
    logic        e_wr = 0, e_ts = 0, e_done = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_dh = '0, e_dc = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_clr = 0; m_nwr = 0;
            e_wr = 0; e_ts = 0; e_done = 0; e_addr = '0; e_dh = '0; e_dc = '0;
        end else begin
            e_wr = 0;
            e_ts = 0;
            case (m_phase)
                0, 3: if (bus.start) begin
                    e_wr = 1; e_addr = '0; e_dh = '0; e_dc = '0; e_done = 0;
                    m_clr = 1; m_nwr = 0; m_phase = 1;
                end
                1: begin
                    e_wr = 1; e_addr = AW'(m_clr); e_dh = '0; e_dc = '0;
                    m_clr++;
                    if (m_clr == NC) m_phase = 2;
                end
                2: if (bus.i_valid) begin
                    int a;
                    a = NC + m_nwr;
                    e_wr = 1; e_addr = AW'(a); e_dh = bus.i_h; e_dc = bus.i_c;
                    e_ts = ((a + 1) % NC) == 0;
                    m_nwr++;
                    if (a == LAST) begin
                        e_done = 1; m_phase = 3;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    logic [DW-1:0] log_h [0:LAST];
    logic [DW-1:0] log_c [0:LAST];
    int            ts_cnt = 0;
    int            ts_first = -1, ts_last = -1;

    always @(negedge clk) begin
        logic e_busy;
        e_busy = (m_phase == 1) || (m_phase == 2);
        check("cycle",
              {4'h0, bus.o_wr_en, bus.o_addr_h, bus.o_addr_c, bus.o_data_h, bus.o_data_c,
               bus.o_ts_done, bus.o_busy, bus.o_done},
              {4'h0, e_wr, e_addr, e_addr, e_dh, e_dc, e_ts, e_busy, e_done});
        if (bus.o_wr_en === 1'b1 && int'(bus.o_addr_h) <= LAST) begin
            log_h[bus.o_addr_h] = bus.o_data_h;
            log_c[bus.o_addr_h] = bus.o_data_c;
        end
        if (bus.o_ts_done === 1'b1) begin
            ts_cnt++;
            if (ts_first < 0) ts_first = int'(bus.o_addr_h);
            ts_last = int'(bus.o_addr_h);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.start = 0; bus.i_valid = 0; bus.i_h = '0; bus.i_c = '0;
        #2 rst_n = 0;
        cyc(2);
        check("reset_outputs", {bus.o_wr_en, bus.o_addr_h, bus.o_data_h, bus.o_busy, bus.o_done}, '0);
        rst_n = 1;
        cyc(1);

        // ---- 1: start and clear ----
        bus.start = 1; cyc(1); bus.start = 0;
        check("clear_first", {bus.o_wr_en, bus.o_addr_h, bus.o_busy}, {1'b1, 12'd0, 1'b1});
        cyc(7);
        check("clear_last", {bus.o_wr_en, bus.o_addr_h, bus.o_data_h}, {1'b1, 12'd7, 16'd0});

        // ---- 2: 56 back-to-back results ----
        ts_cnt = 0; ts_first = -1;
        for (int k = 0; k < 56; k++) begin
            bus.i_valid = 1; bus.i_h = DW'(k); bus.i_c = DW'(16'h100 + k);
            cyc(1);
            if (k == 0) check("first_run_addr", bus.o_addr_h, 12'd8);
        end
        bus.i_valid = 0;
        check("last_write", {bus.o_addr_h, bus.o_data_c, bus.o_ts_done, bus.o_done},
              {12'd63, 16'h137, 1'b1, 1'b1});
        cyc(1);
        check("after_done", {bus.o_busy, bus.o_wr_en, bus.o_done}, {1'b0, 1'b0, 1'b1});
        check("ts_count", ts_cnt, 7);
        check("ts_first", ts_first, 15);
        check("ts_last", ts_last, 63);
        check("log_h40", log_h[40], 16'd32);
        check("log_c8", log_c[8], 16'h100);

        // ---- 6/4: restart from DONE, valid held through clear ----
        bus.start = 1; cyc(1); bus.start = 0;
        check("restart", {bus.o_done, bus.o_wr_en, bus.o_addr_h}, {1'b0, 1'b1, 12'd0});
        bus.i_valid = 1; bus.i_h = 16'hAAAA; bus.i_c = 16'h5555;
        cyc(8);
        check("run_after_clear_valid", {bus.o_addr_h, bus.o_data_h}, {12'd8, 16'hAAAA});
        bus.i_valid = 0;

        // ---- 3/6: sparse valids with start pulses during RUN ----
        for (int k = 1; k < 56; k++) begin
            bus.i_valid = 1; bus.i_h = DW'(16'h200 + k); bus.i_c = DW'(16'h300 + k);
            bus.start = (k % 5 == 2);
            cyc(1);
            bus.i_valid = 0; bus.start = 0;
            cyc(1);
            if (k == 10) check("gap_hold", {bus.o_wr_en, bus.o_addr_h, bus.o_data_h},
                               {1'b0, 12'd18, 16'h20A});
            cyc(1);
        end
        check("sparse_done", {bus.o_done, bus.o_addr_h}, {1'b1, 12'd63});

        // valid held after DONE produces nothing
        bus.i_valid = 1; bus.i_h = 16'hBEEF;
        cyc(4);
        check("done_ignores_valid", {bus.o_wr_en, bus.o_addr_h, bus.o_data_h},
              {1'b0, 12'd63, 16'h237});
        bus.i_valid = 0;

        // ---- 5: reset during the addr-30 write ----
        bus.start = 1; cyc(1); bus.start = 0;
        cyc(7);
        for (int k = 0; k < 22; k++) begin
            bus.i_valid = 1; bus.i_h = DW'(16'h400 + k); bus.i_c = DW'(k);
            cyc(1);
        end
        check("pre_reset_addr", bus.o_addr_h, 12'd29);
        bus.i_h = 16'h0416; bus.i_c = 16'd22;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("async_reset", {bus.o_wr_en, bus.o_addr_h, bus.o_addr_c, bus.o_data_h,
                              bus.o_data_c, bus.o_ts_done, bus.o_busy, bus.o_done}, '0);
        bus.i_valid = 0;
        cyc(2);
        rst_n = 1;
        cyc(1);
        bus.start = 1; cyc(1); bus.start = 0;
        check("clear_again", {bus.o_wr_en, bus.o_addr_h, bus.o_busy}, {1'b1, 12'd0, 1'b1});
        cyc(7);
        bus.i_valid = 1; bus.i_h = 16'h1234; bus.i_c = 16'h4321;
        cyc(1);
        bus.i_valid = 0;
        check("post_reset_first", {bus.o_addr_h, bus.o_data_h}, {12'd8, 16'h1234});
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
